// File: rtl/regfile_loader_pkg.sv
// Shared types and sizing constants for the register-file loader.
// Imported by the top-level FSM and available to any companion blocks.
package regfile_loader_pkg;

  localparam int NUM_REGS       = 32;
  localparam int FIRST_LOAD_REG = 1;
  localparam int VERIFY_PAIRS   = 16;
  localparam int ADDR_W         = $clog2(NUM_REGS);

  localparam logic [ADDR_W-1:0] LAST_LOAD_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] LAST_PAIR_ADDR = ADDR_W'(2 * (VERIFY_PAIRS - 1));

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4
  } loaderState_e;

endpackage

// File: rtl/regfile_loader_checksum32.sv
// 32-bit wrapping accumulator with clear, add-one and add-two operations.
// Clear wins over both adds; add-two wins over add-one.
module checksum32 (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        clear,
  input  logic        addOne,
  input  logic        addTwo,
  input  logic [31:0] addendA,
  input  logic [31:0] addendB,
  output logic [31:0] sum
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (addTwo) begin
      sum <= sum + addendA + addendB;
    end else if (addOne) begin
      sum <= sum + addendA;
    end
  end

endmodule

// File: rtl/regfile_loader.sv
// Loads a 31-word stream into registers 1..31 of the regfile, then reads the
// whole file back in pairs and compares checksums (plus a register-0 check).
module regfile_loader
  import regfile_loader_pkg::*;
#(
  parameter bit CHECK_ZERO = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [31:0] InData,
  input  logic        InValid,
  output logic        InReady,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic        Busy,
  output logic        Done,
  output logic        Pass
);

  loaderState_e state, nextState;

  logic [ADDR_W-1:0] idx;
  logic              zeroOk;
  logic              passHeld;
  logic              accept;
  logic              firstPair;
  logic              lastPair;
  logic              verdict;
  logic              loadClear, loadAdd;
  logic              readClear, readAddOne, readAddTwo;
  logic [31:0]       loadSum, readSum;

  assign accept    = (state == LOAD) && InValid;
  assign firstPair = (ReadRegister1 == '0);
  assign lastPair  = (ReadRegister1 == LAST_PAIR_ADDR);
  assign verdict   = (readSum == loadSum) && (zeroOk || !CHECK_ZERO);

  assign InReady = (state == LOAD);
  assign Busy    = (state == LOAD) || (state == DRAIN) || (state == VERIFY);
  assign Done    = (state == DONE);
  // The verdict is live during DONE and frozen afterwards until the next Start.
  assign Pass    = (state == DONE) ? verdict : passHeld;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    loadClear  = 1'b0;
    loadAdd    = 1'b0;
    readClear  = 1'b0;
    readAddOne = 1'b0;
    readAddTwo = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          nextState = LOAD;
          loadClear = 1'b1;
          readClear = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          loadAdd = 1'b1;
          if (idx == LAST_LOAD_REG) begin
            nextState = DRAIN;
          end
        end
      end
      DRAIN: begin
        nextState = VERIFY;
      end
      VERIFY: begin
        // Register 0 is excluded from the sum; it only feeds the zero check.
        if (firstPair) begin
          readAddOne = 1'b1;
        end else begin
          readAddTwo = 1'b1;
        end
        if (lastPair) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx           <= '0;
      WriteData     <= '0;
      WriteRegister <= '0;
      RegWrite      <= 1'b0;
      ReadRegister1 <= '0;
      ReadRegister2 <= '0;
      zeroOk        <= 1'b0;
      passHeld      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          RegWrite      <= 1'b0;
          ReadRegister1 <= '0;
          ReadRegister2 <= '0;
          if (Start) begin
            idx      <= ADDR_W'(FIRST_LOAD_REG);
            zeroOk   <= 1'b0;
            passHeld <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            WriteData     <= InData;
            WriteRegister <= idx;
            RegWrite      <= 1'b1;
            idx           <= idx + 1'b1;
          end else begin
            RegWrite <= 1'b0;
          end
        end
        DRAIN: begin
          RegWrite      <= 1'b0;
          ReadRegister1 <= '0;
          ReadRegister2 <= 5'd1;
        end
        VERIFY: begin
          if (firstPair) begin
            zeroOk <= (ReadData1 == '0);
          end
          if (lastPair) begin
            ReadRegister1 <= '0;
            ReadRegister2 <= '0;
          end else begin
            ReadRegister1 <= ReadRegister1 + 5'd2;
            ReadRegister2 <= ReadRegister2 + 5'd2;
          end
        end
        DONE: begin
          passHeld <= verdict;
        end
        default: begin
          RegWrite <= 1'b0;
        end
      endcase
    end
  end

  checksum32 loadChecksum (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (loadClear),
    .addOne  (loadAdd),
    .addTwo  (1'b0),
    .addendA (InData),
    .addendB (32'd0),
    .sum     (loadSum)
  );

  checksum32 readChecksum (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (readClear),
    .addOne  (readAddOne),
    .addTwo  (readAddTwo),
    .addendA (ReadData2),
    .addendB (ReadData1),
    .sum     (readSum)
  );

endmodule

// File: doc/regfile_loader.md
# regfile_loader

Bus-master companion to the 32x32 register file: on `Start` it consumes a 31-word valid/ready stream and writes the words into registers 1..31 through the register file write port. It then reads the whole file back through both read ports and checks that register 0 reads zero and that the 32-bit modular sum of registers 1..31 matches the sum of the loaded words. It sits between a boot/test data source and the `regfile`, driving that block's write and read address ports.

## Interface
- `CHECK_ZERO`, 1: when 1, a nonzero register 0 readback forces `Pass`=0.
- `Clk`  in  1  clock; all state updates on posedge.
- `Reset_n`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  begin a load/verify run; sampled only in IDLE.
- `InData`  in  32  stream word.
- `InValid`  in  1  `InData` valid.
- `InReady`  out  1  loader accepts a word this cycle.
- `WriteData`  out  32  to regfile `WriteData`.
- `WriteRegister`  out  5  to regfile `WriteRegister`.
- `RegWrite`  out  1  to regfile `RegWrite`.
- `ReadRegister1`  out  5  to regfile port 1 address.
- `ReadRegister2`  out  5  to regfile port 2 address.
- `ReadData1`  in  32  from regfile port 1 (combinational read).
- `ReadData2`  in  32  from regfile port 2.
- `Busy`  out  1  high in every state except IDLE and DONE.
- `Done`  out  1  one-cycle pulse when the verdict is valid.
- `Pass`  out  1  verdict; held until the next `Start` is accepted.

## Operation
- Reset (async, any state): state=IDLE. All outputs are 0, including `InReady`, `RegWrite`, `Done` and `Pass`. Index and both sums are cleared.
- States and transitions:
  - IDLE: `Start`=1 → LOAD, with idx=1, loadsum=0, readsum=0, `Pass`←0.
  - LOAD: `InReady`=1. On `InValid`&`InReady` at an edge, register `WriteData`←`InData`, `WriteRegister`←idx, `RegWrite`←1, loadsum←loadsum+`InData` (mod 2^32), idx←idx+1. With no handshake, `RegWrite`←0 (stall; no bubble write). After the handshake with idx=31 → DRAIN.
  - DRAIN: one cycle. `InReady`=0. `RegWrite` is still high from the idx-31 capture, and the regfile commits reg 31 at this cycle's closing edge. At that edge: `RegWrite`←0, `ReadRegister1`←0, `ReadRegister2`←1 → VERIFY.
  - VERIFY: 16 cycles, pair p=0..15 with addresses (2p, 2p+1). Each edge samples `ReadData1`/`ReadData2` for the current pair:
    - p=0: zero_ok←(`ReadData1`==0), readsum←readsum+`ReadData2`.
    - p>0: readsum←readsum+`ReadData1`+`ReadData2`.
    - The addresses advance by 2 each cycle. After p=15 → DONE.
  - DONE: `Done`=1 for exactly this cycle. `Pass`=(readsum==loadsum)&(zero_ok|~`CHECK_ZERO`). Next state is IDLE unconditionally.
- `Start` outside IDLE is ignored.
- The read addresses return to 0 in IDLE.
- A checksum collision is an accepted limitation; this block is a smoke check, not exact compare.

## Timing
- Edge E0 samples `Start`; LOAD is active from E0. With `InValid` held high, accepts occur at E1..E31, DRAIN spans E31→E32, VERIFY samples at E33..E48, and `Done` is high E48→E49. Total: 48 cycles from `Start` to `Done`.
- Each stall cycle in LOAD adds one cycle to this total.
- Write latency: a word accepted at edge Ek is committed to the regfile at Ek+1.
- `RegWrite` is never high for two consecutive cycles with the same `WriteRegister` value.
- `InReady` is asserted only in LOAD. `InData` is consumed only on `InValid`&`InReady`.
- Register 0 is never written by this block.
- Reset asserted mid-run: outputs drop to 0 asynchronously and no further writes occur. Registers already written keep their values (regfile has no reset).

## Structure
- Package `regfile_loader_pkg`:
  - State encodings: IDLE=0, LOAD=1, DRAIN=2, VERIFY=3, DONE=4.
  - Constants: `NUM_REGS`=32, `FIRST_LOAD_REG`=1, `VERIFY_PAIRS`=16.
- Sub-module `checksum32`: 32-bit wrapping accumulator with clear, add-one and add-two operations. It is instantiated twice (loadsum, readsum). The FSM and index counter stay in the top.

## Test plan
- Reset, then `Start`; stream words 1..31 with `InValid` held high → `Done` 48 cycles after the `Start` edge, `Pass`=1, regs 1..31 read back 1..31, `RegWrite` never targets reg 0.
- Same stream with `InValid` deasserted for 3 cycles after the 10th word → `Done` at 51 cycles, no write while stalled, `Pass`=1.
- Words 0xFFFFFFFF×31 → sums wrap; `Pass`=1, reg 17 reads 0xFFFFFFFF.
- Substitute a regfile whose reg 0 is writable, with reg 0 preset to 59 → `Pass`=0 with `CHECK_ZERO`=1, `Pass`=1 with `CHECK_ZERO`=0.
- Substitute a regfile that ignores `RegWrite` for reg 25 (holds 0), load 100+i → `Pass`=0.
- Assert `Reset_n`=0 after the 12th accept → `RegWrite`, `InReady`, `Busy` go 0 immediately. A fresh `Start` then completes with `Pass`=1. A `Start` pulsed during VERIFY is ignored (no second `Done`).
